hazard_ctrl: RTL and testbench

Scoreboard-based interlock controller for the 8-stage in-order pipeline.
- Sits beside the IF/ID register and tracks which architectural registers have writes in flight.
- On a read-after-write or write-after-write hazard, stalls the instruction unit and IF/ID and injects a NOP bubble into the register-read stage.
- On HALT, drains the pipeline and holds a halted state until reset.

---
 rtl/hazard_pkg.sv | 48 ++++
 rtl/reg_scoreboard.sv | 61 ++++++
 rtl/hazard_ctrl.sv | 94 +++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for the
// pipeline interlock controller.
package hazard_pkg;

  localparam logic [3:0] OpNop   = 4'h0;
  localparam logic [3:0] OpAdd   = 4'h1;
  localparam logic [3:0] OpSub   = 4'h2;
  localparam logic [3:0] OpAnd   = 4'h3;
  localparam logic [3:0] OpOr    = 4'h4;
  localparam logic [3:0] OpXor   = 4'h5;
  localparam logic [3:0] OpNot   = 4'h6;
  localparam logic [3:0] OpMov   = 4'h7;
  localparam logic [3:0] OpLoad  = 4'h8;
  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpHalt  = 4'hF;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  typedef struct packed {
    logic reads_a;
    logic reads_b;
    logic writes;
    logic is_halt;
  } op_class_t;

  // Undefined encodings fall through to the all-zero (NOP) class.
  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t c;
    c = '0;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
        c.reads_a = 1'b1;
        c.reads_b = 1'b1;
        c.writes  = 1'b1;
      end
      OpNot, OpMov: begin
        c.reads_a = 1'b1;
        c.writes  = 1'b1;
      end
      OpLoad:  c.writes  = 1'b1;
      OpStore: c.reads_a = 1'b1;
      OpHalt:  c.is_halt = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters with busy/full status.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG  = 8,
  parameter int unsigned CNTW  = 3,
  parameter int unsigned RegAw = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en_i,
  input  logic [RegAw-1:0] inc_reg_i,
  input  logic             dec_en_i,
  input  logic [RegAw-1:0] dec_reg_i,
  output logic [NREG-1:0]  busy_o,
  output logic [NREG-1:0]  full_o,
  output logic             all_idle_o
);

  logic [CNTW-1:0] cnt_q [NREG];
  logic [CNTW-1:0] cnt_d [NREG];

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      logic inc_hit;
      logic dec_hit;
      inc_hit  = inc_en_i && (inc_reg_i == RegAw'(r));
      dec_hit  = dec_en_i && (dec_reg_i == RegAw'(r));
      cnt_d[r] = cnt_q[r];
      // Simultaneous issue and write-back cancel; a stray write-back never underflows.
      if (inc_hit && !dec_hit && (cnt_q[r] != '1)) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_hit && !inc_hit && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy_o = '0;
    full_o = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
      full_o[r] = (cnt_q[r] == '1);
    end
    all_idle_o = ~|busy_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard interlock: stalls IF/ID and injects bubbles on RAW/WAW hazards,
// drains and parks the pipeline on HALT, and counts stall cycles.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NREG  = 8,
  parameter int unsigned CNTW  = 3,
  parameter int unsigned PERFW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idValid,
  input  logic [3:0]       idOpcode,
  input  logic [2:0]       idOpA,
  input  logic [2:0]       idOpB,
  input  logic [2:0]       idDest,
  input  logic             wbEn,
  input  logic [2:0]       wbReg,
  output logic             stall,
  output logic             bubble,
  output logic             halted,
  output logic [PERFW-1:0] stallCount
);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [PERFW-1:0] stall_cnt_q, stall_cnt_d;

  op_class_t       cls;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] full;
  logic            all_idle;
  logic            hz;
  logic            run;
  logic            issue;

  reg_scoreboard #(
    .NREG (NREG),
    .CNTW (CNTW),
    .RegAw(3)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .inc_en_i  (issue & cls.writes),
    .inc_reg_i (idDest),
    .dec_en_i  (wbEn),
    .dec_reg_i (wbReg),
    .busy_o    (busy),
    .full_o    (full),
    .all_idle_o(all_idle)
  );

  always_comb begin
    cls = op_class(idOpcode);
    // Busy includes registers retiring this cycle: no forwarding path exists.
    hz  = (cls.reads_a & busy[idOpA]) | (cls.reads_b & busy[idOpB]) |
          (cls.writes & busy[idDest]) | (cls.writes & full[idDest]);
    run    = (state_q == StRun);
    stall  = !reset && (run ? (idValid && hz) : 1'b1);
    bubble = stall;
    issue  = !reset && run && idValid && !hz;
    halted = !reset && halted_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (issue && cls.is_halt) state_d = StDrain;
      StDrain:  if (all_idle) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
    halted_d    = (state_d == StHalted);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk;
  logic       reset;
  logic       idValid;
  logic [3:0] idOpcode;
  logic [2:0] idOpA;
  logic [2:0] idOpB;
  logic [2:0] idDest;
  logic       wbEn;
  logic [2:0] wbReg;
  logic       stall;
  logic       bubble;
  logic       halted;
  logic [7:0] stallCount;

  int n_vec;
  int n_err;
  int sc_exp;

  hazard_ctrl #(
    .NREG (8),
    .CNTW (3),
    .PERFW(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .idValid   (idValid),
    .idOpcode  (idOpcode),
    .idOpA     (idOpA),
    .idOpB     (idOpB),
    .idDest    (idDest),
    .wbEn      (wbEn),
    .wbReg     (wbReg),
    .stall     (stall),
    .bubble    (bubble),
    .halted    (halted),
    .stallCount(stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs just after the edge, then move to the sampling point.
  task automatic set_in(input logic v, input logic [3:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic we,
                        input logic [2:0] wr);
    idValid  = v;
    idOpcode = op;
    idOpA    = a;
    idOpB    = b;
    idDest   = d;
    wbEn     = we;
    wbReg    = wr;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_stall(input string tag, input logic exp);
    check_eq({tag, ".stall"}, {31'd0, stall}, {31'd0, exp});
    check_eq({tag, ".bubble"}, {31'd0, bubble}, {31'd0, exp});
    if (exp) sc_exp++;
  endtask

  task automatic idle_wb(input logic [2:0] r);
    set_in(1'b0, OpNop, 3'd0, 3'd0, 3'd0, 1'b1, r);
    exp_stall("clr", 1'b0);
    next_edge();
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    sc_exp = 0;
    reset  = 1'b1;
    idValid = 1'b0; idOpcode = OpNop; idOpA = '0; idOpB = '0; idDest = '0;
    wbEn = 1'b0; wbReg = '0;
    next_edge();
    set_in(1'b1, OpAdd, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0);
    check_eq("rst.stall", {31'd0, stall}, 32'd0);
    check_eq("rst.bubble", {31'd0, bubble}, 32'd0);
    check_eq("rst.halted", {31'd0, halted}, 32'd0);
    next_edge();
    reset = 1'b0;

    // Independent stream
    set_in(1'b1, OpAdd, 3'd2, 3'd3, 3'd1, 1'b0, 3'd0);
    exp_stall("ind0", 1'b0);
    check_eq("ind0.cnt", {24'd0, stallCount}, 32'd0);
    next_edge();
    set_in(1'b1, OpAdd, 3'd5, 3'd6, 3'd4, 1'b0, 3'd0);
    exp_stall("ind1", 1'b0);
    next_edge();
    set_in(1'b1, OpMov, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0);
    exp_stall("busy1", 1'b1);
    next_edge();
    set_in(1'b1, OpMov, 3'd4, 3'd0, 3'd0, 1'b0, 3'd0);
    exp_stall("busy4", 1'b1);
    next_edge();
    idle_wb(3'd1);
    idle_wb(3'd4);

    // RAW on r1, released one cycle after its write-back
    set_in(1'b1, OpAdd, 3'd2, 3'd3, 3'd1, 1'b0, 3'd0);
    exp_stall("raw0", 1'b0);
    next_edge();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, OpSub, 3'd1, 3'd2, 3'd5, (i == 2), 3'd1);
      exp_stall("raw_wait", 1'b1);
      next_edge();
    end
    set_in(1'b1, OpSub, 3'd1, 3'd2, 3'd5, 1'b0, 3'd0);
    exp_stall("raw_go", 1'b0);
    check_eq("raw.count", {24'd0, stallCount}, sc_exp);
    next_edge();
    idle_wb(3'd5);

    // Same-cycle write-back on the destination: conservative WAW stall
    set_in(1'b1, OpLoad, 3'd0, 3'd0, 3'd2, 1'b0, 3'd0);
    exp_stall("ld2", 1'b0);
    next_edge();
    set_in(1'b1, OpMov, 3'd0, 3'd0, 3'd2, 1'b1, 3'd2);
    exp_stall("waw_wb", 1'b1);
    next_edge();
    set_in(1'b1, OpMov, 3'd0, 3'd0, 3'd2, 1'b0, 3'd0);
    exp_stall("waw_go", 1'b0);
    next_edge();
    set_in(1'b1, OpAdd, 3'd2, 3'd2, 3'd3, 1'b0, 3'd0);
    exp_stall("mov_busy", 1'b1);
    next_edge();
    idle_wb(3'd2);

    // Stray write-back leaves r7 idle
    idle_wb(3'd7);
    set_in(1'b1, OpAdd, 3'd7, 3'd7, 3'd0, 1'b0, 3'd0);
    exp_stall("stray", 1'b0);
    next_edge();
    set_in(1'b1, 4'hA, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    exp_stall("undef", 1'b0);
    next_edge();
    set_in(1'b1, OpStore, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    exp_stall("store", 1'b1);
    next_edge();
    set_in(1'b1, OpStore, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0);
    exp_stall("store_ok", 1'b0);
    next_edge();
    idle_wb(3'd0);

    // HALT with three writes in flight
    for (int r = 1; r <= 3; r++) begin
      set_in(1'b1, OpLoad, 3'd0, 3'd0, 3'(r), 1'b0, 3'd0);
      exp_stall("hld", 1'b0);
      next_edge();
    end
    set_in(1'b1, OpHalt, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    exp_stall("halt", 1'b0);
    next_edge();
    set_in(1'b1, OpAdd, 3'd5, 3'd6, 3'd4, 1'b0, 3'd0);
    exp_stall("drain", 1'b1);
    check_eq("drain.halted", {31'd0, halted}, 32'd0);
    next_edge();
    for (int r = 1; r <= 3; r++) begin
      set_in(1'b0, OpNop, 3'd0, 3'd0, 3'd0, 1'b1, 3'(r));
      exp_stall("drain_wb", 1'b1);
      check_eq("drain_wb.halted", {31'd0, halted}, 32'd0);
      next_edge();
    end
    set_in(1'b1, OpAdd, 3'd5, 3'd6, 3'd4, 1'b0, 3'd0);
    exp_stall("drain_idle", 1'b1);
    check_eq("drain_idle.halted", {31'd0, halted}, 32'd0);
    next_edge();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, OpAdd, 3'd5, 3'd6, 3'd4, 1'b0, 3'd0);
      exp_stall("halted", 1'b1);
      check_eq("halted.halted", {31'd0, halted}, 32'd1);
      next_edge();
    end
    set_in(1'b0, OpNop, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    check_eq("halted.count", {24'd0, stallCount}, sc_exp);

    // Reset out of HALTED
    reset = 1'b1;
    set_in(1'b1, OpAdd, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0);
    check_eq("rst2.stall", {31'd0, stall}, 32'd0);
    check_eq("rst2.halted", {31'd0, halted}, 32'd0);
    next_edge();
    reset  = 1'b0;
    sc_exp = 0;
    set_in(1'b1, OpAdd, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0);
    exp_stall("post_rst", 1'b0);
    check_eq("post_rst.halted", {31'd0, halted}, 32'd0);
    check_eq("post_rst.count", {24'd0, stallCount}, 32'd0);
    next_edge();

    // Stall counter saturation
    for (int i = 0; i < 300; i++) begin
      set_in(1'b1, OpMov, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0);
      next_edge();
    end
    set_in(1'b1, OpMov, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0);
    exp_stall("sat", 1'b1);
    check_eq("sat.count", {24'd0, stallCount}, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
